// File: rtl/uart_pkg.sv
// Shared definitions for the UART host block: default sizing and the
// TX feeder state encoding.
package uart_pkg;

  localparam int unsigned DEFAULT_DEPTH   = 16;
  localparam int unsigned DEFAULT_ACK_TMO = 8;
  localparam int unsigned BYTE_W          = 8;

  // TX feeder: wait for data, strobe the core, wait for busy, wait for done
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } feed_state_e;

endpackage

// File: rtl/uart_host_if.sv
// UART host bus bundle: user TX/RX streams, UART core side, status/control.
//   s_tx_*     : user byte stream into the TX FIFO (valid/ready)
//   m_rx_*     : RX FIFO head to the user (first-word-fall-through)
//   core_*     : transmit request/busy and receive strobe of the UART core
//   tx_level / rx_level, rx_overrun, clr_overrun : status and control
// slave = uart_host view, master = the environment driving it.
interface uart_host_if import uart_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] s_tx_data;
  logic              s_tx_valid;
  logic              s_tx_ready;
  logic [BYTE_W-1:0] m_rx_data;
  logic              m_rx_valid;
  logic              m_rx_ready;
  logic [BYTE_W-1:0] core_data;
  logic              core_valid_tx;
  logic              core_busy_tx;
  logic [BYTE_W-1:0] core_rsr;
  logic              core_valid_rx;
  logic [LVL_W-1:0]  tx_level;
  logic [LVL_W-1:0]  rx_level;
  logic              rx_overrun;
  logic              clr_overrun;

  modport slave (
    input  s_tx_data, s_tx_valid, m_rx_ready, core_busy_tx, core_rsr,
           core_valid_rx, clr_overrun,
    output s_tx_ready, m_rx_data, m_rx_valid, core_data, core_valid_tx,
           tx_level, rx_level, rx_overrun
  );

  modport master (
    output s_tx_data, s_tx_valid, m_rx_ready, core_busy_tx, core_rsr,
           core_valid_rx, clr_overrun,
    input  s_tx_ready, m_rx_data, m_rx_valid, core_data, core_valid_tx,
           tx_level, rx_level, rx_overrun
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through read and level.
//   clk, rstn          : clock, synchronous active-low reset
//   push_i / wdata_i   : write request and data (accepted when not full, or
//                        when full and a pop happens in the same cycle)
//   pop_i              : consume head (ignored when empty)
//   rdata_o            : current head entry
//   empty_o, full_o    : occupancy flags
//   level_o            : number of entries held (0..DEPTH)
module uart_sync_fifo import uart_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [BYTE_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [BYTE_W-1:0]        rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              wr_en, rd_en;

  // Qualified pointer/level update; pointers wrap naturally at DEPTH
  always_comb begin
    rd_en   = pop_i && (level_q != '0);
    wr_en   = push_i && ((level_q != LW'(DEPTH)) || rd_en);
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(rd_en);
    level_d = level_q + LW'(wr_en) - LW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible once written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;

endmodule

// File: rtl/uart_host.sv
// UART host adapter: buffers user bytes into a TX FIFO and feeds them to a
// UART core one at a time, and buffers core-received bytes in an RX FIFO.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : uart_host_if.slave (user streams, core handshake, status)
module uart_host import uart_pkg::*; #(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned ACK_TMO = DEFAULT_ACK_TMO
) (
  input  logic       clk,
  input  logic       rstn,
  uart_host_if.slave bus
);

  localparam int unsigned TMO_W = $clog2(ACK_TMO + 1);

  feed_state_e       state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] core_data_q, core_data_d;
  logic              valid_tx_q, valid_tx_d;
  logic              ovr_q, ovr_d;

  logic              tx_push, tx_pop, tx_empty, tx_full;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_push, rx_pop, rx_empty, rx_full, rx_drop;
  logic [BYTE_W-1:0] rx_head;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (tx_push),
    .wdata_i (bus.s_tx_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .level_o (bus.tx_level)
  );

  uart_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rx_push),
    .wdata_i (bus.core_rsr),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .level_o (bus.rx_level)
  );

  // Stream handshakes; a full RX FIFO still accepts when the user pops
  always_comb begin
    tx_push = bus.s_tx_valid && !tx_full;
    rx_pop  = !rx_empty && bus.m_rx_ready;
    rx_push = bus.core_valid_rx && (!rx_full || rx_pop);
    rx_drop = bus.core_valid_rx && rx_full && !rx_pop;
    // A drop in the same cycle as a clear keeps the flag set
    if (rx_drop) begin
      ovr_d = 1'b1;
    end else if (bus.clr_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Feeder next-state: the head is captured on entry to ISSUE and popped
  // at the end of ISSUE, so core_data holds until the next issue
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    core_data_d = core_data_q;
    tx_pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty && !bus.core_busy_tx) begin
          state_d     = ISSUE;
          core_data_d = tx_head;
        end
      end
      ISSUE: begin
        tx_pop  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.core_busy_tx) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
          // Core never acknowledged: treat the byte as sent
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.core_busy_tx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_tx_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      core_data_q <= '0;
      valid_tx_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      core_data_q <= core_data_d;
      valid_tx_q  <= valid_tx_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.s_tx_ready    = !tx_full;
  assign bus.m_rx_data     = rx_head;
  assign bus.m_rx_valid    = !rx_empty;
  assign bus.core_data     = core_data_q;
  assign bus.core_valid_tx = valid_tx_q;
  assign bus.rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_host.sv
// Self-checking bench for uart_host: RX vector table, directed TX sequences
// and a randomized run against a queue-based reference model.
module tb_uart_host;
  import uart_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ACK_TMO = 8;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_host_if #(.DEPTH(DEPTH)) bus ();

  uart_host #(.DEPTH(DEPTH), .ACK_TMO(ACK_TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Core transmitter model: busy for a programmable number of cycles after
  // each transmit strobe (0 = never acknowledges); logs every strobe.
  bit          force_busy = 1'b0;
  bit          rand_len   = 1'b0;
  int          ack_len    = 0;
  int          busy_cnt   = 0;
  logic [7:0]  pulse_data [$];
  int          pulse_cyc  [$];

  always begin
    @(posedge clk);
    #2;
    if (!rstn) busy_cnt = 0;
    bus.core_busy_tx = force_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    if (bus.core_valid_tx === 1'b1) begin
      pulse_data.push_back(bus.core_data);
      pulse_cyc.push_back(cyc);
      busy_cnt = rand_len ? int'($urandom_range(0, 6)) : ack_len;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstn              = 1'b0;
    bus.s_tx_valid    = 1'b0;
    bus.s_tx_data     = 8'h00;
    bus.m_rx_ready    = 1'b0;
    bus.core_rsr      = 8'h00;
    bus.core_valid_rx = 1'b0;
    bus.clr_overrun   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " s_tx_ready"},    32'(bus.s_tx_ready),    32'd1);
    chk({tag, " m_rx_valid"},    32'(bus.m_rx_valid),    32'd0);
    chk({tag, " tx_level"},      32'(bus.tx_level),      32'd0);
    chk({tag, " rx_level"},      32'(bus.rx_level),      32'd0);
    chk({tag, " core_valid_tx"}, 32'(bus.core_valid_tx), 32'd0);
    chk({tag, " core_data"},     32'(bus.core_data),     32'd0);
    chk({tag, " rx_overrun"},    32'(bus.rx_overrun),    32'd0);
  endtask

  task automatic wait_pulses(input int n, input int limit);
    int k;
    k = 0;
    while (pulse_data.size() < n && k < limit) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("pulse wait", 32'(pulse_data.size() >= n), 32'd1);
  endtask

  // RX vector table
  typedef struct {
    logic       vrx;
    logic [7:0] rsr;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_head;
    int         exp_level;
    logic       exp_ov;
  } rx_vec_t;

  rx_vec_t vt [37];

  function automatic rx_vec_t mk(input logic vrx, input logic [7:0] rsr, input logic rdy,
                                 input logic clr, input logic ev, input logic [7:0] eh,
                                 input int el, input logic eo);
    rx_vec_t v;
    v.vrx = vrx; v.rsr = rsr; v.rdy = rdy; v.clr = clr;
    v.exp_valid = ev; v.exp_head = eh; v.exp_level = el; v.exp_ov = eo;
    return v;
  endfunction

  // Reference model state for the randomized run
  logic [7:0] mtx [$];
  logic [7:0] mrx [$];
  logic       mov;
  logic [7:0] last_data;
  int         last_pulse;

  task automatic rnd_cycle(input logic tv, input logic [7:0] td, input logic vrx,
                           input logic [7:0] rsr, input logic rdy, input logic clr);
    bit tx_pop, tx_push, rx_pop, rx_push, rx_drop;
    chk("rnd s_tx_ready", 32'(bus.s_tx_ready), 32'(mtx.size() < DEPTH));
    chk("rnd tx_level",   32'(bus.tx_level),   32'(mtx.size()));
    chk("rnd m_rx_valid", 32'(bus.m_rx_valid), 32'(mrx.size() != 0));
    chk("rnd rx_level",   32'(bus.rx_level),   32'(mrx.size()));
    chk("rnd rx_overrun", 32'(bus.rx_overrun), 32'(mov));
    if (mrx.size() != 0) chk("rnd m_rx_data", 32'(bus.m_rx_data), 32'(mrx[0]));
    tx_pop = 1'b0;
    if (bus.core_valid_tx === 1'b1) begin
      chk("rnd issue with data queued", 32'(mtx.size() != 0), 32'd1);
      chk("rnd issue spacing", 32'(cyc - last_pulse >= 3), 32'd1);
      chk("rnd issue while busy", 32'(bus.core_busy_tx), 32'd0);
      last_pulse = cyc;
      if (mtx.size() != 0) begin
        chk("rnd core_data", 32'(bus.core_data), 32'(mtx[0]));
        last_data = mtx[0];
        tx_pop    = 1'b1;
      end
    end else begin
      chk("rnd core_data hold", 32'(bus.core_data), 32'(last_data));
    end
    bus.s_tx_valid    = tv;
    bus.s_tx_data     = td;
    bus.core_valid_rx = vrx;
    bus.core_rsr      = rsr;
    bus.m_rx_ready    = rdy;
    bus.clr_overrun   = clr;
    tx_push = tv && (mtx.size() < DEPTH);
    if (tx_pop) void'(mtx.pop_front());
    if (tx_push) mtx.push_back(td);
    rx_pop  = (mrx.size() != 0) && rdy;
    rx_push = vrx && ((mrx.size() < DEPTH) || rx_pop);
    rx_drop = vrx && !rx_push;
    if (rx_pop) void'(mrx.pop_front());
    if (rx_push) mrx.push_back(rsr);
    mov = rx_drop ? 1'b1 : (clr ? 1'b0 : mov);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, base, k;

    for (int i = 0; i < 16; i++) vt[i] = mk(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 8'h00, i + 1, 1'b0);
    vt[16] = mk(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00, 16, 1'b1);
    vt[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 16, 1'b0);
    vt[18] = mk(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h00, 16, 1'b1);
    vt[19] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 16, 1'b0);
    vt[20] = mk(1'b1, 8'hAB, 1'b1, 1'b0, 1'b1, 8'h01, 16, 1'b0);
    for (int j = 0; j < 15; j++)
      vt[21 + j] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, (j < 14) ? 8'(2 + j) : 8'hAB, 15 - j, 1'b0);
    vt[36] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0);

    // Reset state
    do_reset();
    check_reset_state("reset");

    // RX table: fill to overrun, clear, set-wins, full push+pop, drain
    for (int i = 0; i < 37; i++) begin
      bus.core_valid_rx = vt[i].vrx;
      bus.core_rsr      = vt[i].rsr;
      bus.m_rx_ready    = vt[i].rdy;
      bus.clr_overrun   = vt[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("rxtab[%0d] m_rx_valid", i), 32'(bus.m_rx_valid), 32'(vt[i].exp_valid));
      chk($sformatf("rxtab[%0d] rx_level", i),   32'(bus.rx_level),   32'(vt[i].exp_level));
      chk($sformatf("rxtab[%0d] rx_overrun", i), 32'(bus.rx_overrun), 32'(vt[i].exp_ov));
      if (vt[i].exp_valid)
        chk($sformatf("rxtab[%0d] m_rx_data", i), 32'(bus.m_rx_data), 32'(vt[i].exp_head));
    end
    bus.core_valid_rx = 1'b0;
    bus.m_rx_ready    = 1'b0;
    bus.clr_overrun   = 1'b0;

    // Two bytes, core busy 10 cycles after each strobe
    do_reset();
    ack_len = 10;
    base    = pulse_data.size();
    c       = cyc;
    bus.s_tx_valid = 1'b1;
    bus.s_tx_data  = 8'h55;
    @(posedge clk); #1;
    bus.s_tx_data  = 8'hA3;
    @(posedge clk); #1;
    bus.s_tx_valid = 1'b0;
    wait_pulses(base + 2, 80);
    if (pulse_data.size() >= base + 2) begin
      chk("busy10 first data",  32'(pulse_data[base]),     32'h55);
      chk("busy10 second data", 32'(pulse_data[base + 1]), 32'hA3);
      chk("busy10 first latency", 32'(pulse_cyc[base] - c), 32'd2);
      chk("busy10 spacing", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'd13);
    end
    @(posedge clk); #1;

    // TX FIFO fill with core held busy, then 17th byte after one issue
    force_busy = 1'b1;
    do_reset();
    base = pulse_data.size();
    for (int i = 0; i < 17; i++) begin
      bus.s_tx_valid = 1'b1;
      bus.s_tx_data  = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    chk("fill tx_level", 32'(bus.tx_level), 32'd16);
    chk("fill s_tx_ready", 32'(bus.s_tx_ready), 32'd0);
    chk("fill no issue while busy", 32'(pulse_data.size()), 32'(base));
    ack_len    = 3;
    force_busy = 1'b0;
    k = 0;
    while (bus.s_tx_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("fill ready after issue", 32'(bus.s_tx_ready), 32'd1);
    chk("fill one issue", 32'(pulse_data.size()), 32'(base + 1));
    if (pulse_data.size() > base) chk("fill first data", 32'(pulse_data[base]), 32'h30);
    @(posedge clk); #1;
    bus.s_tx_valid = 1'b0;
    chk("fill 17th accepted", 32'(bus.tx_level), 32'd16);

    // Core never acknowledges: ACK timeout path
    do_reset();
    ack_len = 0;
    base    = pulse_data.size();
    c       = cyc;
    bus.s_tx_valid = 1'b1;
    bus.s_tx_data  = 8'h11;
    @(posedge clk); #1;
    bus.s_tx_data  = 8'h22;
    @(posedge clk); #1;
    bus.s_tx_valid = 1'b0;
    wait_pulses(base + 2, 60);
    if (pulse_data.size() >= base + 2) begin
      chk("tmo first data",  32'(pulse_data[base]),     32'h11);
      chk("tmo second data", 32'(pulse_data[base + 1]), 32'h22);
      chk("tmo first latency", 32'(pulse_cyc[base] - c), 32'd2);
      chk("tmo spacing", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'd10);
    end
    @(posedge clk); #1;

    // Reset while waiting for the core to finish, 5 bytes still queued
    do_reset();
    ack_len = 10;
    base    = pulse_data.size();
    for (int i = 0; i < 6; i++) begin
      bus.s_tx_valid    = 1'b1;
      bus.s_tx_data     = 8'(8'h60 + i);
      bus.core_valid_rx = (i < 2);
      bus.core_rsr      = 8'(8'h90 + i);
      @(posedge clk); #1;
    end
    bus.s_tx_valid    = 1'b0;
    bus.core_valid_rx = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("midrst issues before", 32'(pulse_data.size()), 32'(base + 1));
    chk("midrst tx_level before", 32'(bus.tx_level), 32'd5);
    chk("midrst rx_level before", 32'(bus.rx_level), 32'd2);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst post[%0d] core_valid_tx", i), 32'(bus.core_valid_tx), 32'd0);
      chk($sformatf("midrst post[%0d] tx_level", i), 32'(bus.tx_level), 32'd0);
    end

    // Randomized traffic on both directions against the queue model
    rand_len = 1'b1;
    do_reset();
    mtx.delete();
    mrx.delete();
    mov        = 1'b0;
    last_data  = 8'h00;
    last_pulse = cyc - 100;
    for (int n = 0; n < 3000; n++) begin
      rnd_cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 1)), 8'($urandom),
                (n < 1500) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 15) == 0));
    end
    k = 0;
    while ((mtx.size() != 0 || mrx.size() != 0) && k < 600) begin
      rnd_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      k++;
    end
    chk("rnd drain tx", 32'(mtx.size()), 32'd0);
    chk("rnd drain rx", 32'(mrx.size()), 32'd0);
    chk("rnd drain tx_level", 32'(bus.tx_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
